mouse_packet: RTL and testbench

MOUSE_PACKET -- requirements
Module: mouse_packet

---
 rtl/ps2_pkg.sv | 16 +
 rtl/pos_accum.sv | 46 ++++
 rtl/mouse_packet.sv | 150 +++++++++++++++
 tb/tb_mouse_packet.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive stack.
//   ps2_state_e : packet-assembly FSM states
//   PS2_ACK     : acknowledge byte the mouse sends after host commands
//   ACC_W       : width of signed position-accumulation intermediates
package ps2_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } ps2_state_e;

  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam int         ACC_W   = 12;

endpackage

// File: rtl/pos_accum.sv
// pos_accum: one axis of the pointer position. On Update it adds Delta,
// or subtracts it when Invert is set, and clamps the result to 0..MAX.
// The position does not move while Hold (the overflow flag) is set.
//   Clk, Reset : clock, synchronous active-high reset (Pos -> MAX/2)
//   Update     : apply Delta this cycle
//   Hold       : suppress the update
//   Invert     : subtract Delta instead of adding it
//   Delta      : signed 9-bit movement
//   Pos        : clamped position
module pos_accum
  import ps2_pkg::*;
#(
  parameter int MAX = 639
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Update,
  input  logic              Hold,
  input  logic              Invert,
  input  logic signed [8:0] Delta,
  output logic        [9:0] Pos
);

  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX);

  logic signed [ACC_W-1:0] step_raw;
  logic signed [ACC_W-1:0] step;
  logic signed [ACC_W-1:0] sum;
  logic        [9:0]       pos_nxt;

  // 12 bits cover 0..1023 plus or minus 256 with no wrap at either bound.
  always_comb begin
    step_raw = {{(ACC_W-9){Delta[8]}}, Delta};
    step     = Invert ? -step_raw : step_raw;
    sum      = $signed({2'b00, Pos}) + step;
    if (sum < 0)          pos_nxt = '0;
    else if (sum > MAX_S) pos_nxt = MAX_S[9:0];
    else                  pos_nxt = sum[9:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset)                Pos <= 10'(MAX / 2);
    else if (Update && !Hold) Pos <= pos_nxt;
  end

endmodule

// File: rtl/mouse_packet.sv
// mouse_packet: assembles 3-byte PS/2 mouse packets and tracks a clamped
// screen position.
//   Clk, Reset  : clock, synchronous active-high reset
//   RxData      : byte from the PS/2 receiver
//   RxDone      : byte-complete level; a rising edge marks a new byte
//   Buttons     : {M,R,L} of the last packet
//   DX, DY      : signed deltas of the last packet
//   XOvf, YOvf  : overflow bits of the last packet
//   PacketValid : one-cycle pulse when the packet outputs are new
//   XPos, YPos  : clamped accumulated position (Y grows down the screen)
//   SyncErr     : one-cycle pulse when a byte is discarded or a packet times out
//
// state   | meaning
// WAIT_B0 | idle, expecting a header byte (bit3 set); ACK bytes ignored
// WAIT_B1 | header held, expecting X low byte
// WAIT_B2 | X low held, expecting Y low byte; packet completes on it
module mouse_packet
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int X_MAX          = 639,
  parameter int Y_MAX          = 479
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic        [7:0] RxData,
  input  logic              RxDone,
  output logic        [2:0] Buttons,
  output logic signed [8:0] DX,
  output logic signed [8:0] DY,
  output logic              XOvf,
  output logic              YOvf,
  output logic              PacketValid,
  output logic        [9:0] XPos,
  output logic        [9:0] YPos,
  output logic              SyncErr
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ps2_state_e       state, state_nxt, state_eff;
  logic             rx_done_q, rx_done_qq;
  logic [7:0]       rx_data_q;
  logic [7:0]       hdr, xlo;
  logic [CNT_W-1:0] cnt;
  logic             byte_stb, timeout;
  logic             hdr_ld, xlo_ld, pkt_nxt, sync_err_nxt;

  // RxDone and RxData are registered together, so the byte is taken from
  // the register stage on the cycle after the rising edge.
  assign byte_stb = rx_done_q & ~rx_done_qq;
  assign timeout  = (state != WAIT_B0) && (cnt == CNT_TC);

  always_ff @(posedge Clk) begin
    if (Reset) state <= WAIT_B0;
    else       state <= state_nxt;
  end

  // A timeout drops back to WAIT_B0 first, so a byte arriving in the same
  // cycle is judged as a header candidate.
  always_comb begin
    state_eff    = timeout ? WAIT_B0 : state;
    state_nxt    = state_eff;
    hdr_ld       = 1'b0;
    xlo_ld       = 1'b0;
    pkt_nxt      = 1'b0;
    sync_err_nxt = timeout;
    if (byte_stb) begin
      case (state_eff)
        WAIT_B0: begin
          if (rx_data_q == PS2_ACK) begin
            state_nxt = WAIT_B0;
          end else if (!rx_data_q[3]) begin
            sync_err_nxt = 1'b1;
          end else begin
            hdr_ld    = 1'b1;
            state_nxt = WAIT_B1;
          end
        end
        WAIT_B1: begin
          xlo_ld    = 1'b1;
          state_nxt = WAIT_B2;
        end
        WAIT_B2: begin
          pkt_nxt   = 1'b1;
          state_nxt = WAIT_B0;
        end
        default: state_nxt = WAIT_B0;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_done_q   <= 1'b0;
      rx_done_qq  <= 1'b0;
      rx_data_q   <= '0;
      hdr         <= '0;
      xlo         <= '0;
      cnt         <= '0;
      Buttons     <= '0;
      DX          <= '0;
      DY          <= '0;
      XOvf        <= 1'b0;
      YOvf        <= 1'b0;
      PacketValid <= 1'b0;
      SyncErr     <= 1'b0;
    end else begin
      rx_done_q   <= RxDone;
      rx_done_qq  <= rx_done_q;
      rx_data_q   <= RxData;
      if (hdr_ld) hdr <= rx_data_q;
      if (xlo_ld) xlo <= rx_data_q;
      if (byte_stb || state_nxt == WAIT_B0) cnt <= '0;
      else                                  cnt <= cnt + CNT_ONE;
      if (pkt_nxt) begin
        Buttons <= hdr[2:0];
        DX      <= {hdr[4], xlo};
        DY      <= {hdr[5], rx_data_q};
        XOvf    <= hdr[6];
        YOvf    <= hdr[7];
      end
      PacketValid <= pkt_nxt;
      SyncErr     <= sync_err_nxt;
    end
  end

  pos_accum #(.MAX(X_MAX)) u_x_accum (
    .Clk    (Clk),
    .Reset  (Reset),
    .Update (PacketValid),
    .Hold   (XOvf),
    .Invert (1'b0),
    .Delta  (DX),
    .Pos    (XPos)
  );

  pos_accum #(.MAX(Y_MAX)) u_y_accum (
    .Clk    (Clk),
    .Reset  (Reset),
    .Update (PacketValid),
    .Hold   (YOvf),
    .Invert (1'b1),
    .Delta  (DY),
    .Pos    (YPos)
  );

endmodule

// File: tb/tb_mouse_packet.sv
// tb_mouse_packet: directed and random byte streams against a packet-level
// reference model of the mouse decoder.
module tb_mouse_packet;

  localparam int TO    = 40;
  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic        [7:0] RxData = 8'h00;
  logic              RxDone = 1'b0;
  logic        [2:0] Buttons;
  logic signed [8:0] DX, DY;
  logic              XOvf, YOvf, PacketValid, SyncErr;
  logic        [9:0] XPos, YPos;

  mouse_packet #(.TIMEOUT_CYCLES(TO), .X_MAX(X_MAX), .Y_MAX(Y_MAX)) dut (
    .Clk(Clk), .Reset(Reset), .RxData(RxData), .RxDone(RxDone),
    .Buttons(Buttons), .DX(DX), .DY(DY), .XOvf(XOvf), .YOvf(YOvf),
    .PacketValid(PacketValid), .XPos(XPos), .YPos(YPos), .SyncErr(SyncErr)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // pulse-high cycle counters; equal to pulse counts only for 1-cycle pulses
  int pv_seen = 0;
  int se_seen = 0;
  always @(posedge Clk) begin
    if (PacketValid === 1'b1) pv_seen <= pv_seen + 1;
    if (SyncErr === 1'b1)     se_seen <= se_seen + 1;
  end

  // reference model: byte position within packet, last packet, position
  int         m_idx;
  logic [7:0] m_hdr, m_xlo;
  int         m_btn, m_dx, m_dy, m_xovf, m_yovf, m_x, m_y;
  int         pv_exp = 0;
  int         se_exp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_hdr = 0; m_xlo = 0;
    m_btn = 0; m_dx = 0; m_dy = 0; m_xovf = 0; m_yovf = 0;
    m_x = X_MAX / 2; m_y = Y_MAX / 2;
  endtask

  task automatic model_byte(input logic [7:0] b, output logic pkt);
    pkt = 1'b0;
    if (m_idx == 0) begin
      if (b == 8'hFA) begin
      end else if (b[3] == 1'b0) begin
        se_exp++;
      end else begin
        m_hdr = b; m_idx = 1;
      end
    end else if (m_idx == 1) begin
      m_xlo = b; m_idx = 2;
    end else begin
      m_idx  = 0;
      pkt    = 1'b1;
      pv_exp++;
      m_btn  = int'(m_hdr[2:0]);
      m_dx   = m_hdr[4] ? int'(m_xlo) - 256 : int'(m_xlo);
      m_dy   = m_hdr[5] ? int'(b) - 256 : int'(b);
      m_xovf = int'(m_hdr[6]);
      m_yovf = int'(m_hdr[7]);
      if (m_xovf == 0) m_x = clampi(m_x + m_dx, X_MAX);
      if (m_yovf == 0) m_y = clampi(m_y - m_dy, Y_MAX);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".buttons"}, 32'(Buttons), m_btn);
    chk({tag, ".dx"},      32'(DX),      m_dx);
    chk({tag, ".dy"},      32'(DY),      m_dy);
    chk({tag, ".xovf"},    32'(XOvf),    m_xovf);
    chk({tag, ".yovf"},    32'(YOvf),    m_yovf);
    chk({tag, ".xpos"},    32'(XPos),    m_x);
    chk({tag, ".ypos"},    32'(YPos),    m_y);
    chk({tag, ".pv_count"}, pv_seen, pv_exp);
    chk({tag, ".se_count"}, se_seen, se_exp);
  endtask

  // called on a falling edge; returns on a falling edge
  task automatic send(input logic [7:0] b, input int hold, input int gap);
    logic pkt;
    model_byte(b, pkt);
    RxData = b;
    RxDone = 1'b1;
    @(negedge Clk);
    chk("pv_early", 32'(PacketValid), 0);
    @(negedge Clk);
    chk("pv_latency", 32'(PacketValid), 32'(pkt));
    repeat (hold - 2) @(negedge Clk);
    RxDone = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic sendq(input logic [7:0] b);
    send(b, 2, 3);
  endtask

  // idle spans are either short (no timeout) or far beyond TO (timeout)
  task automatic wait_idle(input int n);
    if (n >= TO + 10 && m_idx != 0) begin
      m_idx = 0;
      se_exp++;
    end
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    @(negedge Clk);
  endtask

  initial begin
    begin : watchdog
      fork
        begin
          #2_000_000;
          $display("FAIL watchdog: simulation time limit reached");
          $fatal(1, "timeout");
        end
      join_none
    end
  end

  initial begin
    logic [7:0] b;
    int         r;

    model_reset();
    repeat (3) @(negedge Clk);
    do_reset();
    chk_outputs("reset");
    chk("reset.pv", 32'(PacketValid), 0);
    chk("reset.se", 32'(SyncErr), 0);

    // basic packet, DX=+5 DY=-3
    sendq(8'h29); sendq(8'h05); sendq(8'hFD);
    chk_outputs("pkt_basic");
    chk("pkt_basic.xpos_const", 32'(XPos), 324);
    chk("pkt_basic.ypos_const", 32'(YPos), 242);

    // ACK ignored before header
    do_reset();
    sendq(8'hFA); sendq(8'h08); sendq(8'h10); sendq(8'h20);
    chk_outputs("ack_skip");
    chk("ack_skip.ypos_const", 32'(YPos), 207);

    // out-of-sync byte
    sendq(8'h00);
    chk("sync_err_count", se_seen, se_exp);
    sendq(8'h08); sendq(8'h01); sendq(8'h01);
    chk_outputs("after_sync");

    // long byte hold: accepted once per edge
    send(8'h09, 6, 4); send(8'h02, 5, 3); send(8'h03, 4, 3);
    chk_outputs("long_hold");

    // short gaps stay inside the inter-byte window
    sendq(8'h08); wait_idle(15); sendq(8'h01); wait_idle(15); sendq(8'h01);
    chk_outputs("short_gap");

    // inter-byte timeout
    sendq(8'h08);
    wait_idle(3 * TO);
    chk("timeout.se", se_seen, se_exp);
    chk("timeout.pv", pv_seen, pv_exp);
    sendq(8'h18); sendq(8'hFF); sendq(8'h00);
    chk_outputs("post_timeout");

    // X saturation, then overflow holds position
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sendq(8'h08); sendq(8'h7F); sendq(8'h00);
    end
    chk_outputs("x_sat");
    chk("x_sat.const", 32'(XPos), 639);
    sendq(8'h48); sendq(8'hFF); sendq(8'h00);
    chk_outputs("x_ovf");
    chk("x_ovf.flag", 32'(XOvf), 1);

    // reset mid-packet discards partial bytes
    do_reset();
    sendq(8'h08); sendq(8'h05);
    do_reset();
    sendq(8'h09); sendq(8'h01); sendq(8'h01);
    chk_outputs("mid_reset");
    chk("mid_reset.xpos_const", 32'(XPos), 320);

    // random stream
    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        b = 8'hFA;
        send(b, int'($urandom_range(2, 5)), int'($urandom_range(3, 6)));
      end else if (r < 14) begin
        b = 8'($urandom()) & 8'hF7;
        send(b, int'($urandom_range(2, 5)), int'($urandom_range(3, 6)));
      end else if (r < 17) begin
        wait_idle(2 * TO + 20);
      end else begin
        b = 8'($urandom());
        if (m_idx == 0) b[3] = 1'b1;
        send(b, int'($urandom_range(2, 5)), int'($urandom_range(3, 6)));
      end
      if (i % 10 == 9) chk_outputs("random");
    end
    chk_outputs("random_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
